// File: rtl/vga_timing.sv
// 640x480@60 raster timing generator: pixel/line counters, phase FSMs,
// registered sync/active-video outputs, line/frame pulses and a frame counter.
module vga_timing #(
  parameter int   H_ACTIVE  = 640,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BP      = 48,
  parameter int   V_ACTIVE  = 480,
  parameter int   V_FP      = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BP      = 33,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0
) (
  input  logic        pixel_clock,
  input  logic        rst,
  input  logic        ce,
  output logic [9:0]  hPos,
  output logic [9:0]  vPos,
  output logic        videoOn,
  output logic        hsync,
  output logic        vsync,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_FRONT_AT = 10'(H_ACTIVE);
  localparam logic [9:0] H_SYNC_AT  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_BACK_AT  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_FRONT_AT = 10'(V_ACTIVE);
  localparam logic [9:0] V_SYNC_AT  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_BACK_AT  = 10'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [1:0] H_ACT   = 2'd0;
  localparam logic [1:0] H_FRONT = 2'd1;
  localparam logic [1:0] H_SYNCS = 2'd2;
  localparam logic [1:0] H_BACK  = 2'd3;
  localparam logic [1:0] V_ACT   = 2'd0;
  localparam logic [1:0] V_FRONT = 2'd1;
  localparam logic [1:0] V_SYNCS = 2'd2;
  localparam logic [1:0] V_BACK  = 2'd3;

  // Shared phase-FSM step: the state is decided by the position about to be shown.
  function automatic logic [1:0] phase_step(
    input logic [1:0] st,
    input logic [9:0] pos,
    input logic [9:0] front_at,
    input logic [9:0] sync_at,
    input logic [9:0] back_at
  );
    logic [1:0] nxt;
    nxt = st;
    case (st)
      2'd0: if (pos == front_at) nxt = 2'd1; else nxt = 2'd0;
      2'd1: if (pos == sync_at)  nxt = 2'd2; else nxt = 2'd1;
      2'd2: if (pos == back_at)  nxt = 2'd3; else nxt = 2'd2;
      2'd3: if (pos == 10'd0)    nxt = 2'd0; else nxt = 2'd3;
      default: nxt = 2'd3;
    endcase
    return nxt;
  endfunction

  logic [9:0]  h_q, h_d, v_q, v_d;
  logic [1:0]  hst_q, hst_d, vst_q, vst_d;
  logic        von_q, von_d, hs_q, hs_d, vs_q, vs_d;
  logic        ls_q, ls_d, fs_q, fs_d;
  logic [15:0] fc_q, fc_d;

  logic       h_wrap, v_wrap;
  logic [9:0] h_inc, v_inc;

  assign h_wrap = (h_q == H_LAST);
  assign v_wrap = (v_q == V_LAST);
  assign h_inc  = h_wrap ? 10'd0 : h_q + 10'd1;
  assign v_inc  = v_wrap ? 10'd0 : v_q + 10'd1;

  // Next-state: everything steps on ce except the pulses, which always clear.
  always_comb begin
    h_d   = h_q;
    v_d   = v_q;
    hst_d = hst_q;
    vst_d = vst_q;
    fc_d  = fc_q;
    ls_d  = 1'b0;
    fs_d  = 1'b0;
    if (ce) begin
      h_d   = h_inc;
      ls_d  = h_wrap;
      fs_d  = h_wrap & v_wrap;
      hst_d = phase_step(hst_q, h_inc, H_FRONT_AT, H_SYNC_AT, H_BACK_AT);
      if (h_wrap) begin
        v_d   = v_inc;
        vst_d = phase_step(vst_q, v_inc, V_FRONT_AT, V_SYNC_AT, V_BACK_AT);
      end else begin
        v_d   = v_q;
        vst_d = vst_q;
      end
      if (h_wrap && v_wrap) begin
        fc_d = fc_q + 16'd1;
      end else begin
        fc_d = fc_q;
      end
    end else begin
      h_d   = h_q;
      v_d   = v_q;
      hst_d = hst_q;
      vst_d = vst_q;
      fc_d  = fc_q;
    end
  end

  // Decoded from next phase so sync/active line up with the coordinates beside them.
  always_comb begin
    von_d = (hst_d == H_ACT) && (vst_d == V_ACT);
    if (hst_d == H_SYNCS) begin
      hs_d = HSYNC_POL;
    end else begin
      hs_d = ~HSYNC_POL;
    end
    if (vst_d == V_SYNCS) begin
      vs_d = VSYNC_POL;
    end else begin
      vs_d = ~VSYNC_POL;
    end
  end

  // State and output registers; reset parks on the last blanking pixel of a frame.
  always_ff @(posedge pixel_clock) begin
    if (rst) begin
      h_q   <= H_LAST;
      v_q   <= V_LAST;
      hst_q <= H_BACK;
      vst_q <= V_BACK;
      von_q <= 1'b0;
      hs_q  <= ~HSYNC_POL;
      vs_q  <= ~VSYNC_POL;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
      fc_q  <= 16'd0;
    end else begin
      h_q   <= h_d;
      v_q   <= v_d;
      hst_q <= hst_d;
      vst_q <= vst_d;
      von_q <= von_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      ls_q  <= ls_d;
      fs_q  <= fs_d;
      fc_q  <= fc_d;
    end
  end

  assign hPos        = h_q;
  assign vPos        = v_q;
  assign videoOn     = von_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign frame_count = fc_q;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: default-timing instance plus a tiny-timing instance,
// a reference-model scoreboard checked every cycle, and per-scenario measurements.
module tb_vga_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, ce_a = 1'b0, rst_b = 1'b1, ce_b = 1'b0;
  logic [9:0] ha, va, hb, vb;
  logic von_a, hs_a, vs_a, ls_a, fs_a, von_b, hs_b, vs_b, ls_b, fs_b;
  logic [15:0] fc_a, fc_b;

  vga_timing dut_a (
    .pixel_clock(clk), .rst(rst_a), .ce(ce_a), .hPos(ha), .vPos(va), .videoOn(von_a),
    .hsync(hs_a), .vsync(vs_a), .line_start(ls_a), .frame_start(fs_a), .frame_count(fc_a)
  );

  vga_timing #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut_b (
    .pixel_clock(clk), .rst(rst_b), .ce(ce_b), .hPos(hb), .vPos(vb), .videoOn(von_b),
    .hsync(hs_b), .vsync(vs_b), .line_start(ls_b), .frame_start(fs_b), .frame_count(fc_b)
  );

  typedef struct packed {
    logic [9:0]  h;
    logic [9:0]  v;
    logic        von, hs, vs, ls, fs;
    logic [15:0] fc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int errors = 0;
  int checks = 0;

  int mah = 0, mav = 0, mbh = 0, mbv = 0;
  logic [15:0] mafc = 16'd0, mbfc = 16'd0;
  logic mals = 1'b0, mafs = 1'b0, mbls = 1'b0, mbfs = 1'b0;

  // Reference counter model: position advances on ce, pulses only on the enabled wrap.
  task automatic mstep(input int ht, input int vt, input logic r, input logic c,
                       inout int h, inout int v, inout logic [15:0] fc,
                       inout logic ls, inout logic fs);
    if (r) begin
      h = ht - 1; v = vt - 1; fc = 16'd0; ls = 1'b0; fs = 1'b0;
    end else if (c) begin
      if (h == ht - 1) begin
        h = 0;
        v = (v == vt - 1) ? 0 : v + 1;
      end else begin
        h = h + 1;
      end
      ls = (h == 0);
      fs = ls && (v == 0);
      if (fs) fc = fc + 16'd1;
    end else begin
      ls = 1'b0; fs = 1'b0;
    end
  endtask

  function automatic exp_t mk(input int h, input int v, input logic [15:0] fc,
                              input logic ls, input logic fs,
                              input int hact, input int hfp, input int hsw,
                              input int vact, input int vfp, input int vsw);
    exp_t e;
    e.h   = 10'(h);
    e.v   = 10'(v);
    e.von = (h < hact) && (v < vact);
    e.hs  = !((h >= hact + hfp) && (h < hact + hfp + hsw));
    e.vs  = !((v >= vact + vfp) && (v < vact + vfp + vsw));
    e.ls  = ls;
    e.fs  = fs;
    e.fc  = fc;
    return e;
  endfunction

  // One pixel clock of stimulus for both instances; expectations go to the scoreboard.
  task automatic drive(input logic ra, input logic ca, input logic rb, input logic cb);
    @(negedge clk);
    rst_a = ra; ce_a = ca; rst_b = rb; ce_b = cb;
    mstep(800, 525, ra, ca, mah, mav, mafc, mals, mafs);
    qa.push_back(mk(mah, mav, mafc, mals, mafs, 640, 16, 96, 480, 10, 2));
    mstep(7, 5, rb, cb, mbh, mbv, mbfc, mbls, mbfs);
    qb.push_back(mk(mbh, mbv, mbfc, mbls, mbfs, 4, 1, 1, 2, 1, 1));
  endtask

  // Scoreboard: compare each instance against the model just after every edge.
  always @(posedge clk) begin
    exp_t e;
    exp_t g;
    #1;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      g = {ha, va, von_a, hs_a, vs_a, ls_a, fs_a, fc_a};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL sb_a t=%0t: got h=%0d v=%0d von=%b hs=%b vs=%b ls=%b fs=%b fc=%h want h=%0d v=%0d von=%b hs=%b vs=%b ls=%b fs=%b fc=%h",
                 $time, g.h, g.v, g.von, g.hs, g.vs, g.ls, g.fs, g.fc,
                 e.h, e.v, e.von, e.hs, e.vs, e.ls, e.fs, e.fc);
      end
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      g = {hb, vb, von_b, hs_b, vs_b, ls_b, fs_b, fc_b};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL sb_b t=%0t: got h=%0d v=%0d von=%b hs=%b vs=%b ls=%b fs=%b fc=%h want h=%0d v=%0d von=%b hs=%b vs=%b ls=%b fs=%b fc=%h",
                 $time, g.h, g.v, g.von, g.hs, g.vs, g.ls, g.fs, g.fc,
                 e.h, e.v, e.von, e.hs, e.vs, e.ls, e.fs, e.fc);
      end
    end
  end

  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    @(posedge clk); #1;
    checks++;
    if ({ha, va, von_a, hs_a, vs_a, ls_a, fs_a, fc_a} !==
        {10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0}) begin
      errors++;
      $display("FAIL reset_state: got h=%0d v=%0d von=%b hs=%b vs=%b ls=%b fs=%b fc=%h want 799 524 0 1 1 0 0 0000",
               ha, va, von_a, hs_a, vs_a, ls_a, fs_a, fc_a);
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    checks++;
    if ({ha, va, von_a, ls_a, fs_a, fc_a} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 16'd1}) begin
      errors++;
      $display("FAIL release_first: got h=%0d v=%0d von=%b ls=%b fs=%b fc=%h want 0 0 1 1 1 0001",
               ha, va, von_a, ls_a, fs_a, fc_a);
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    checks++;
    if ({ha, ls_a, fs_a} !== {10'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL release_second: got h=%0d ls=%b fs=%b want 1 0 0", ha, ls_a, fs_a);
    end
  endtask

  task automatic test_line_scan();
    int n = 1, fall_h = -1, low_cnt = 0, first_low = -1, last_low = -1, period = -1;
    logic prev_von;
    prev_von = von_a;
    for (int i = 0; i < 900; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      @(posedge clk); #1;
      n++;
      if (prev_von && !von_a) fall_h = int'(ha);
      prev_von = von_a;
      if (!hs_a) begin
        low_cnt++;
        if (first_low < 0) first_low = int'(ha);
        last_low = int'(ha);
      end
      if (ls_a) begin
        period = n;
        break;
      end
    end
    checks++;
    if (fall_h != 640) begin errors++; $display("FAIL videoOn_fall: got h=%0d want 640", fall_h); end
    checks++;
    if (low_cnt != 96) begin errors++; $display("FAIL hsync_width: got %0d want 96", low_cnt); end
    checks++;
    if (first_low != 656 || last_low != 751) begin
      errors++;
      $display("FAIL hsync_window: got %0d..%0d want 656..751", first_low, last_low);
    end
    checks++;
    if (period != 800) begin errors++; $display("FAIL line_period: got %0d want 800", period); end
  endtask

  task automatic test_ce_gating();
    int ls_cnt = 0, ls_long = 0, run = 0, runs = 0, last_run = -1;
    logic prev_ls = 1'b0;
    for (int i = 0; i < 1800; i++) begin
      drive(1'b0, (i % 2) == 0, 1'b1, 1'b0);
      @(posedge clk); #1;
      if (ls_a) ls_cnt++;
      if (ls_a && prev_ls) ls_long++;
      prev_ls = ls_a;
      if (!hs_a) begin
        run++;
      end else if (run > 0) begin
        runs++;
        last_run = run;
        run = 0;
      end
    end
    checks++;
    if (ls_cnt != 1 || ls_long != 0) begin
      errors++;
      $display("FAIL ce_line_pulse: got count=%0d stretched=%0d want 1 0", ls_cnt, ls_long);
    end
    checks++;
    if (runs != 1 || last_run != 192) begin
      errors++;
      $display("FAIL ce_hsync_width: got runs=%0d len=%0d want 1 192", runs, last_run);
    end
    checks++;
    if ({ha, va} !== {10'd100, 10'd2}) begin
      errors++;
      $display("FAIL ce_advance: got h=%0d v=%0d want 100 2", ha, va);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 1000; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      @(posedge clk); #1;
      if (ha == 10'd700) break;
    end
    checks++;
    if ({ha, va} !== {10'd700, 10'd2}) begin
      errors++;
      $display("FAIL midframe_reach: got h=%0d v=%0d want 700 2", ha, va);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    checks++;
    if ({ha, va, von_a, hs_a, vs_a, ls_a, fs_a, fc_a} !==
        {10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0}) begin
      errors++;
      $display("FAIL midframe_reset: got h=%0d v=%0d von=%b hs=%b vs=%b fc=%h want 799 524 0 1 1 0000",
               ha, va, von_a, hs_a, vs_a, fc_a);
    end
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    checks++;
    if ({ha, va, von_a, ls_a, fs_a, fc_a} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 16'd1}) begin
      errors++;
      $display("FAIL midframe_restart: got h=%0d v=%0d von=%b ls=%b fs=%b fc=%h want 0 0 1 1 1 0001",
               ha, va, von_a, ls_a, fs_a, fc_a);
    end
  endtask

  task automatic test_frame_scan();
    int last_fs = -1, bad_period = 0, run = 0, last_run = -1, hmax = 0, vmax = 0, bad_pair = 0;
    for (int i = 0; i < 110; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      @(posedge clk); #1;
      if (int'(hb) > hmax) hmax = int'(hb);
      if (int'(vb) > vmax) vmax = int'(vb);
      if (fs_b) begin
        if (!ls_b) bad_pair++;
        if (last_fs >= 0 && i - last_fs != 35) bad_period++;
        last_fs = i;
      end
      if (!vs_b) begin
        run++;
      end else if (run > 0) begin
        last_run = run;
        run = 0;
      end
    end
    checks++;
    if (bad_period != 0 || bad_pair != 0) begin
      errors++;
      $display("FAIL frame_period: got bad_periods=%0d fs_without_ls=%0d want 0 0", bad_period, bad_pair);
    end
    checks++;
    if (last_run != 7) begin errors++; $display("FAIL vsync_width: got %0d want 7", last_run); end
    checks++;
    if (hmax != 6 || vmax != 4) begin
      errors++;
      $display("FAIL counter_max: got h=%0d v=%0d want 6 4", hmax, vmax);
    end
    checks++;
    if (fc_b !== 16'd4) begin errors++; $display("FAIL frame_count: got %h want 0004", fc_b); end
  endtask

  task automatic test_frame_wrap();
    int nfs = 0;
    #2;
    force dut_b.fc_q = 16'hFFFE;
    #1;
    release dut_b.fc_q;
    mbfc = 16'hFFFE;
    for (int i = 0; i < 80; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      @(posedge clk); #1;
      if (fs_b) begin
        nfs++;
        checks++;
        if (nfs == 1 && fc_b !== 16'hFFFF) begin
          errors++;
          $display("FAIL wrap_ffff: got %h want ffff", fc_b);
        end
        if (nfs == 2 && fc_b !== 16'h0000) begin
          errors++;
          $display("FAIL wrap_zero: got %h want 0000", fc_b);
        end
        if (nfs == 2) break;
      end
    end
    checks++;
    if (nfs != 2) begin errors++; $display("FAIL wrap_frames: got %0d frame pulses want 2", nfs); end
  endtask

  initial begin
    test_reset();
    test_line_scan();
    test_ce_gating();
    test_reset_mid();
    test_frame_scan();
    test_frame_wrap();
    @(posedge clk); #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
